// File: rtl/mem_arbiter.sv
// Unified memory-port sequencer shared by the fetch and load/store requesters.
// One access in flight; data has priority, bounded by a fetch starvation counter.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q;
    logic [3:0]          lat_cnt_q;
    logic [3:0]          starve_cnt_q;
    logic                owner_q;      // 1 = data requester owns the access
    logic                mem_en_q;
    logic                mem_we_q;
    logic [2:0]          mem_func3_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                if_rvalid_q;
    logic                d_rvalid_q;
    logic                pick_d_d;
    logic                pick_if_d;

    always_comb begin
        pick_d_d  = d_req && !(if_req && (starve_cnt_q == STARVE_LIM));
        pick_if_d = if_req && !pick_d_d;
        // Grants are gated by rst so nothing is accepted while reset is held.
        d_gnt     = rst && (state_q == IDLE) && pick_d_d;
        if_gnt    = rst && (state_q == IDLE) && pick_if_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_func3_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            mem_en_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_gnt) begin
                        state_q     <= ISSUE;
                        mem_en_q    <= 1'b1;
                        owner_q     <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_func3_q <= d_func3;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        if (if_req && (starve_cnt_q < STARVE_LIM)) begin
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                        end
                    end else if (if_gnt) begin
                        state_q      <= ISSUE;
                        mem_en_q     <= 1'b1;
                        owner_q      <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_func3_q  <= 3'b010;
                        mem_addr_q   <= if_addr;
                        mem_wdata_q  <= '0;
                        starve_cnt_q <= '0;
                    end
                end
                ISSUE: begin
                    state_q   <= WAIT;
                    lat_cnt_q <= LAT_INIT;
                end
                WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        state_q <= RESP;
                        if (owner_q) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= mem_we_q ? '0 : mem_rdata;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_func3 = mem_func3_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a cycle-timeline reference model predicts
// grants, memory strobes and responses from the arbitration and latency rules.
module tb_mem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          LAT  = 2;
    localparam int          SMAX = 4;
    localparam int          NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [2:0]    d_func3;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we, busy;
    logic [2:0]    mem_func3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: absolute cycle numbers of the in-flight access.
    bit          infl;
    int          free_at, issue_at, sample_at, resp_at;
    bit          own_d;
    logic [31:0] e_addr, e_wdata, e_resp, held_if, held_d;
    logic        e_we;
    logic [2:0]  e_f3;
    int          starve;
    bit          gi_prev, gd_prev;
    bit          contend;
    int          n_cgr;
    logic [9:0]  cseq;

    task automatic model_reset();
        infl    = 1'b0;
        free_at = 0;
        starve  = 0;
        held_if = '0;
        held_d  = '0;
    endtask

    task automatic drive_inputs();
        if (cyc < 3) rst = 1'b0;
        else if (cyc == 3) rst = 1'b1;
        else if (!rst) rst = 1'b1;
        else if (!contend && infl && cyc > issue_at && $urandom_range(0, 99) == 0) rst = 1'b0;

        if (!if_req || gi_prev) begin
            if_req  = contend ? 1'b1 : 1'($urandom_range(0, 1));
            if_addr = $urandom;
        end else if (!contend && $urandom_range(0, 15) == 0) begin
            if_req = 1'b0;
        end
        if (!d_req || gd_prev) begin
            d_req   = contend ? 1'b1 : 1'($urandom_range(0, 1));
            d_we    = 1'($urandom_range(0, 1));
            d_func3 = 3'($urandom_range(0, 7));
            d_addr  = $urandom;
            d_wdata = $urandom;
        end else if (!contend && $urandom_range(0, 15) == 0) begin
            d_req = 1'b0;
        end
        mem_rdata = (infl && cyc == sample_at) ? e_resp : $urandom;
    endtask

    task automatic check_and_step();
        bit idle, ed, ei, en_exp, rv_exp;
        if (!rst) model_reset();
        idle = rst && (cyc >= free_at);
        ed   = idle && d_req && !(if_req && starve == SMAX);
        ei   = idle && if_req && !ed;
        check_eq("grant", 32'({if_gnt, d_gnt}), 32'({ei, ed}));
        check_eq("busy", 32'(busy), 32'(rst && cyc < free_at));

        en_exp = infl && cyc == issue_at;
        check_eq("mem_en", 32'(mem_en), 32'(en_exp));
        if (en_exp) begin
            check_eq("mem_addr", mem_addr, e_addr);
            check_eq("mem_we", 32'(mem_we), 32'(e_we));
            check_eq("mem_func3", 32'(mem_func3), 32'(e_f3));
            if (e_we) check_eq("mem_wdata", mem_wdata, e_wdata);
        end
        if (!rst) check_eq("reset_mem_regs", 32'({mem_we, mem_func3}) | mem_addr | mem_wdata, 32'd0);

        rv_exp = infl && cyc == resp_at;
        if (rv_exp) begin
            if (own_d) held_d = e_we ? 32'd0 : e_resp;
            else       held_if = e_resp;
            infl = 1'b0;
        end
        check_eq("if_rvalid", 32'(if_rvalid), 32'(rv_exp && !own_d));
        check_eq("d_rvalid", 32'(d_rvalid), 32'(rv_exp && own_d));
        check_eq("if_rdata", if_rdata, held_if);
        check_eq("d_rdata", d_rdata, held_d);

        if (ei || ed) begin
            infl      = 1'b1;
            issue_at  = cyc + 1;
            sample_at = cyc + 1 + LAT;
            resp_at   = cyc + 2 + LAT;
            free_at   = cyc + 3 + LAT;
            own_d     = ed;
            e_resp    = $urandom;
            if (ed) begin
                e_addr = d_addr; e_we = d_we; e_f3 = d_func3; e_wdata = d_wdata;
                if (if_req && starve < SMAX) starve++;
            end else begin
                e_addr = if_addr; e_we = 1'b0; e_f3 = 3'b010; e_wdata = '0;
                starve = 0;
            end
        end
        gi_prev = ei;
        gd_prev = ed;

        // Under continuous contention the observed grant order is D,D,D,D,I repeating.
        if (contend && rst && (if_gnt || d_gnt)) begin
            cseq = {cseq[8:0], if_gnt};
            n_cgr++;
            if (n_cgr == 10) begin
                check_eq("grant_order", 32'(cseq), 32'(10'b0000100001));
                contend = 1'b0;
            end
        end
        if (contend && cyc > 200) begin
            check_eq("contention_timeout", 32'(n_cgr), 32'd10);
            contend = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b1; if_addr = '0;
        d_req = 1'b1; d_we = 1'b0; d_func3 = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        gi_prev = 1'b0; gd_prev = 1'b0;
        contend = 1'b1; n_cgr = 0; cseq = '0;
        issue_at = 0; sample_at = 0; resp_at = 0; own_d = 1'b0;
        e_addr = '0; e_wdata = '0; e_resp = '0; e_we = 1'b0; e_f3 = '0;
        model_reset();
        while (cyc < NCYC) begin
            @(posedge clk);
            #1;
            drive_inputs();
            @(negedge clk);
            check_and_step();
            cyc++;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
